// File: rtl/alu_seq.sv
// Registered ALU with iterative unsigned MULU/DIVU; single-cycle ops complete on the accepting edge,
// MULU/DIVU(B!=0) take WIDTH cycles. start is ignored while busy; no other backpressure.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUoperation,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               is_div;

    logic               accept;
    logic               b_zero;
    logic               go_run;
    logic [WIDTH-1:0]   sc_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] step_nxt;

    assign accept = start && (state == IDLE);
    assign b_zero = (B == '0);
    assign go_run = (ALUoperation == OP_MULU) || ((ALUoperation == OP_DIVU) && !b_zero);
    assign busy   = (state == RUN);

    // acc = {partial product, remaining multiplier bits}; one multiplier bit retired per cycle
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign step_nxt = is_div ? div_nxt : mul_nxt;

    always_comb begin
        sc_res = '0;
        case (ALUoperation)
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_ADD:  sc_res = A + B;
            OP_SUB:  sc_res = A - B;
            OP_SLT:  sc_res[0] = ($signed(A) < $signed(B));
            OP_SLTU: sc_res[0] = (A < B);
            OP_XOR:  sc_res = A ^ B;
            OP_NOR:  sc_res = ~(A | B);
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && go_run) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            opnd        <= '0;
            acc         <= '0;
            is_div      <= 1'b0;
            ALUResult   <= '0;
            hi          <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt <= '0;
                if (ALUoperation == OP_MULU) begin
                    acc    <= {{WIDTH{1'b0}}, B};
                    opnd   <= A;
                    is_div <= 1'b0;
                end else if (ALUoperation == OP_DIVU && !b_zero) begin
                    acc    <= {{WIDTH{1'b0}}, A};
                    opnd   <= B;
                    is_div <= 1'b1;
                end else if (ALUoperation == OP_DIVU) begin
                    ALUResult   <= '1;
                    hi          <= A;
                    zero        <= 1'b0;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end else begin
                    ALUResult   <= sc_res;
                    hi          <= '0;
                    zero        <= (sc_res == '0);
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
            end else if (state == RUN) begin
                acc <= step_nxt;
                cnt <= cnt + ONE;
                // results only leave the datapath on the final iteration
                if (cnt == LAST) begin
                    ALUResult   <= step_nxt[WIDTH-1:0];
                    hi          <= step_nxt[2*WIDTH-1:WIDTH];
                    zero        <= (step_nxt[WIDTH-1:0] == '0);
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start32, start8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [3:0]  op32, op8;
    logic [31:0] res32, hi32;
    logic [7:0]  res8, hi8;
    logic        z32, dbz32, busy32, done32;
    logic        z8, dbz8, busy8, done8;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .ALUoperation(op32),
        .ALUResult(res32), .hi(hi32), .zero(z32), .div_by_zero(dbz32), .busy(busy32), .done(done32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .ALUoperation(op8),
        .ALUResult(res8), .hi(hi8), .zero(z8), .div_by_zero(dbz8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] o_res(input bit w8);
        return w8 ? {56'd0, res8} : {32'd0, res32};
    endfunction
    function automatic logic [63:0] o_hi(input bit w8);
        return w8 ? {56'd0, hi8} : {32'd0, hi32};
    endfunction
    function automatic logic o_z(input bit w8);
        return w8 ? z8 : z32;
    endfunction
    function automatic logic o_dbz(input bit w8);
        return w8 ? dbz8 : dbz32;
    endfunction
    function automatic logic o_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction
    function automatic logic o_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    // Reference: plain unsigned/signed arithmetic on 64-bit values; lat = edges after accept until done
    task automatic model(input bit w8, input logic [3:0] op, input logic [63:0] a_in, input logic [63:0] b_in,
                         output logic [63:0] r, output logic [63:0] h, output logic d, output int lat);
        int          w;
        logic [63:0] mask, a, b, p;
        longint      sa, sb;
        w    = w8 ? 8 : 32;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
        r = 0; h = 0; d = 1'b0; lat = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = (a + b) & mask;
            4'd6:  r = (a - b) & mask;
            4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd8:  begin p = a * b; r = p & mask; h = p >> w; lat = w; end
            4'd9:  begin
                if (b == 0) begin r = mask; h = a; d = 1'b1; end
                else begin r = a / b; h = a % b; lat = w; end
            end
            4'd10: r = (a < b) ? 64'd1 : 64'd0;
            4'd11: r = a ^ b;
            4'd12: r = ~(a | b) & mask;
            default: r = 0;
        endcase
    endtask

    // Called #1 after a rising edge; returns edges after the accept edge until done, and busy samples
    task automatic do_op(input bit w8, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int cyc, output int bsy);
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; op8 = op; start8 = 1'b1; end
        else begin a32 = a[31:0]; b32 = b[31:0]; op32 = op; start32 = 1'b1; end
        tick();
        start8 = 1'b0;
        start32 = 1'b0;
        cyc = 0;
        bsy = 0;
        while (!o_done(w8) && cyc < 200) begin
            if (o_busy(w8)) bsy++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({res32, hi32, z32, dbz32, busy32, done32} !== {64'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset32: got res=%h hi=%h z=%b dbz=%b busy=%b done=%b, want 0 0 1 0 0 0",
                     res32, hi32, z32, dbz32, busy32, done32);
        end
        checks++;
        if ({res8, hi8, z8, dbz8, busy8, done8} !== {16'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset8: got res=%h hi=%h z=%b dbz=%b busy=%b done=%b, want 0 0 1 0 0 0",
                     res8, hi8, z8, dbz8, busy8, done8);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [3:0]  ops [4] = '{4'd6, 4'd7, 4'd10, 4'd12};
        logic [31:0] as  [4] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] bs  [4] = '{32'd5, 32'd1, 32'd1, 32'd0};
        logic [31:0] rs  [4] = '{32'd0, 32'd1, 32'd0, 32'hFFFFFFFF};
        int cyc, bsy;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, ops[i], {32'd0, as[i]}, {32'd0, bs[i]}, cyc, bsy);
            checks++;
            if (res32 !== rs[i] || hi32 !== 32'd0 || z32 !== (rs[i] == 0) || dbz32 !== 1'b0 || cyc != 0) begin
                errors++;
                $display("FAIL single_op%0d: got res=%h hi=%h z=%b dbz=%b lat=%0d, want res=%h hi=0 z=%b dbz=0 lat=0",
                         ops[i], res32, hi32, z32, dbz32, cyc, rs[i], rs[i] == 0);
            end
        end
        tick();
        checks++;
        if (done32 !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, want 0", done32);
        end
    endtask

    task automatic test_mul;
        int cyc, bsy;
        do_op(1'b0, 4'd8, 64'hFFFFFFFF, 64'hFFFFFFFF, cyc, bsy);
        checks++;
        if (hi32 !== 32'hFFFFFFFE || res32 !== 32'h00000001 || cyc != 32 || bsy != 32 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL mulu_max: got hi=%h res=%h lat=%0d busy_cycles=%0d busy=%b, want FFFFFFFE 00000001 32 32 0",
                     hi32, res32, cyc, bsy, busy32);
        end
    endtask

    task automatic test_div;
        int cyc, bsy;
        do_op(1'b0, 4'd9, 64'd100, 64'd7, cyc, bsy);
        checks++;
        if (res32 !== 32'd14 || hi32 !== 32'd2 || dbz32 !== 1'b0 || cyc != 32) begin
            errors++;
            $display("FAIL divu_100_7: got q=%0d r=%0d dbz=%b lat=%0d, want 14 2 0 32", res32, hi32, dbz32, cyc);
        end
        do_op(1'b0, 4'd9, 64'd9, 64'd0, cyc, bsy);
        checks++;
        if (res32 !== 32'hFFFFFFFF || hi32 !== 32'd9 || dbz32 !== 1'b1 || z32 !== 1'b0 || cyc != 0) begin
            errors++;
            $display("FAIL divu_by_zero: got q=%h r=%0d dbz=%b z=%b lat=%0d, want FFFFFFFF 9 1 0 0",
                     res32, hi32, dbz32, z32, cyc);
        end
    endtask

    task automatic test_random(input bit w8, input int n);
        logic [63:0] a, b, er, eh;
        logic [3:0]  op;
        logic        ed;
        int          elat, cyc, bsy;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = {32'd0, $urandom()};
            b  = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'd0, $urandom()};
            if (w8) begin a = a & 64'hFF; b = b & 64'hFF; end
            model(w8, op, a, b, er, eh, ed, elat);
            do_op(w8, op, a, b, cyc, bsy);
            checks++;
            if (o_res(w8) !== er || o_hi(w8) !== eh || o_dbz(w8) !== ed || o_z(w8) !== (er == 0) || cyc != elat) begin
                errors++;
                $display("FAIL rand_w%0d op=%0d a=%h b=%h: got res=%h hi=%h dbz=%b z=%b lat=%0d, want %h %h %b %b %0d",
                         w8 ? 8 : 32, op, a, b, o_res(w8), o_hi(w8), o_dbz(w8), o_z(w8), cyc, er, eh, ed, er == 0, elat);
            end
        end
    endtask

    task automatic test_ignore;
        logic [63:0] er, eh;
        logic        ed;
        int          elat, cyc;
        model(1'b0, 4'd8, 64'h12345678, 64'h9ABCDEF0, er, eh, ed, elat);
        a32 = 32'h12345678; b32 = 32'h9ABCDEF0; op32 = 4'd8; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        cyc = 0;
        while (!done32 && cyc < 200) begin
            if (cyc == 5) begin a32 = 32'd3; b32 = 32'd4; op32 = 4'd2; start32 = 1'b1; end
            else start32 = 1'b0;
            tick();
            cyc++;
        end
        start32 = 1'b0;
        checks++;
        if ({32'd0, res32} !== er || {32'd0, hi32} !== eh || cyc != 32) begin
            errors++;
            $display("FAIL ignore_start: got res=%h hi=%h lat=%0d, want %h %h 32", res32, hi32, cyc, er[31:0], eh[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bsy;
        do_op(1'b0, 4'd8, 64'd6, 64'd7, cyc, bsy);
        checks++;
        if (done32 !== 1'b1 || res32 !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first: got done=%b res=%0d, want 1 42", done32, res32);
        end
        a32 = 32'd3; b32 = 32'd4; op32 = 4'd2; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        checks++;
        if (done32 !== 1'b1 || res32 !== 32'd7 || hi32 !== 32'd0) begin
            errors++;
            $display("FAIL b2b_add: got done=%b res=%0d hi=%h, want 1 7 0", done32, res32, hi32);
        end
        tick();
        checks++;
        if (done32 !== 1'b0 || res32 !== 32'd7) begin
            errors++;
            $display("FAIL b2b_hold: got done=%b res=%0d, want 0 7", done32, res32);
        end
    endtask

    task automatic test_w8;
        int cyc, bsy;
        do_op(1'b1, 4'd8, 64'hFF, 64'h02, cyc, bsy);
        checks++;
        if (hi8 !== 8'h01 || res8 !== 8'hFE || cyc != 8 || bsy != 8) begin
            errors++;
            $display("FAIL w8_mulu: got hi=%h res=%h lat=%0d busy_cycles=%0d, want 01 FE 8 8", hi8, res8, cyc, bsy);
        end
        do_op(1'b1, 4'd2, 64'hFF, 64'h01, cyc, bsy);
        checks++;
        if (res8 !== 8'h00 || z8 !== 1'b1 || cyc != 0) begin
            errors++;
            $display("FAIL w8_add_wrap: got res=%h z=%b lat=%0d, want 00 1 0", res8, z8, cyc);
        end
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        a32 = 32'hDEADBEEF; b32 = 32'h0000F00D; op32 = 4'd8; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({res32, hi32, z32, dbz32, busy32, done32} !== {64'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_mid_mul: got res=%h hi=%h z=%b dbz=%b busy=%b done=%b, want 0 0 1 0 0 0",
                     res32, hi32, z32, dbz32, busy32, done32);
        end
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done32 || busy32) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort: done/busy seen %0d cycles after reset, want 0", seen);
        end
    endtask

    initial begin
        start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; op32 = '0;
        a8 = '0; b8 = '0; op8 = '0;
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_ignore();
        test_back_to_back();
        test_w8();
        test_random(1'b0, 30);
        test_random(1'b1, 30);
        test_reset_mid_mul();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised successor to the pipeline's single-cycle ALU. It registers all results and adds an iterative unsigned multiplier and divider behind a start/done handshake. It sits in the EX stage: the hazard unit stalls the pipeline while `busy` is high. The legacy 3-bit op codes are preserved as the low codes of a 4-bit op field.

## Interface

- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request; accepted only when `busy` = 0.
- `A` input WIDTH: operand A, captured on accept.
- `B` input WIDTH: operand B, captured on accept.
- `ALUoperation` input 4: operation code, captured on accept.
- `ALUResult` output WIDTH: primary result; low product for MULU, quotient for DIVU.
- `hi` output WIDTH: high product for MULU, remainder for DIVU, 0 for all other ops.
- `zero` output 1: 1 when `ALUResult` = 0.
- `div_by_zero` output 1: 1 when the last DIVU had B = 0.
- `busy` output 1: an iterative operation is in progress.
- `done` output 1: one-cycle pulse; results are valid from this cycle on.

## Operation

- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^WIDTH).
  - 0110 SUB (wraps); 0111 SLT (signed: result is 1 if A < B, else 0).
  - 1000 MULU; 1001 DIVU; 1010 SLTU (unsigned); 1011 XOR; 1100 NOR.
  - Any other code: `ALUResult` = 0, `hi` = 0, completes as a single-cycle op.
- FSM states: IDLE and RUN. A WIDTH-bit iteration counter runs in RUN.
- In IDLE, `start` = 1 accepts the request. Operands and op are captured.
  - Single-cycle ops, undefined codes, and DIVU with B = 0: outputs are written on the accepting edge, `done` pulses, and the FSM stays in IDLE.
  - MULU: go to RUN. Shift-add over WIDTH iterations, one bit of B per cycle, LSB first, into a 2·WIDTH accumulator. Final outputs: {`hi`, `ALUResult`} = A·B, unsigned.
  - DIVU with B ≠ 0: go to RUN. Restoring division over WIDTH iterations, one quotient bit per cycle, MSB first. Final outputs: quotient and remainder, unsigned.
- DIVU with B = 0: `ALUResult` = all ones, `hi` = A, `div_by_zero` = 1.
  - Every other accepted op clears `div_by_zero`.
- `zero` is recomputed whenever `ALUResult` is written.
- Outputs hold their last values until the next completion. Intermediate iteration values never appear on the outputs.
- `start` is ignored while `busy` = 1; operands are not re-sampled.

## Timing

- Reset (`rst` = 0, asynchronous):
  - FSM goes to IDLE and the counter clears.
  - `ALUResult` = 0, `hi` = 0, `zero` = 1, `div_by_zero` = 0, `busy` = 0, `done` = 0.
  - Reset during RUN aborts the operation; no `done` is produced.
- Single-cycle op accepted at edge k: results and `done` = 1 are visible after edge k. `done` drops after edge k+1 unless another op completes at that edge.
- MULU, or DIVU with B ≠ 0, accepted at edge k:
  - `busy` = 1 after edge k, through edge k+WIDTH−1.
  - Outputs are written and `done` = 1 after edge k+WIDTH; `busy` = 0 in that same cycle.
  - Latency is therefore WIDTH cycles.
- Back-to-back: `start` in the `done` cycle is accepted, because `busy` = 0. A single-cycle op accepted there makes `done` stay high for a second consecutive cycle.
- `busy` is a registered output, decoded from state only; it has no combinational path from `start`.

## Test plan

- Reset: drive `rst` = 0 mid-MULU at cycle 5. Required: outputs go to their reset values immediately, and no `done` is seen afterwards until a new `start`.
- Single-cycle ops, WIDTH = 32:
  - SUB 5−5 → `ALUResult` 0, `zero` 1, `done` 1 cycle after accept.
  - SLT with A = 0xFFFFFFFF, B = 1 → 1.
  - SLTU with the same operands → 0.
  - NOR 0,0 → 0xFFFFFFFF.
- MULU with A = 0xFFFFFFFF, B = 0xFFFFFFFF. Required: after exactly 32 cycles, `hi` = 0xFFFFFFFE and `ALUResult` = 0x00000001; `busy` is high for exactly 32 cycles.
- DIVU 100 / 7: `ALUResult` = 14, `hi` = 2, `div_by_zero` = 0, latency 32. DIVU 9 / 0: `ALUResult` = 0xFFFFFFFF, `hi` = 9, `div_by_zero` = 1, latency 1.
- Ignore and back-to-back:
  - Pulse `start` with different operands mid-MULU. Required: the result is unchanged.
  - Issue ADD 3+4 in the `done` cycle. Required: 7 with `done` high for 2 consecutive cycles.
- WIDTH = 8: MULU 0xFF·0x02 → `hi` = 0x01, `ALUResult` = 0xFE, latency 8. ADD 0xFF+0x01 → 0x00, `zero` = 1.
